// File: rtl/edc_pkg.sv
// Shared types and constants for the error-correction stage that follows
// the error-location lookup.
package edc_pkg;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  typedef logic [2:0] flg_t;

  localparam flg_t FLG_CLEAN  = 3'b001;
  localparam flg_t FLG_CORR   = 3'b010;
  localparam flg_t FLG_UNCORR = 3'b100;

  typedef struct packed {
    flg_t flg;
    logic flip_en;
  } cls_t;

endpackage

// File: rtl/edc_lq_classify.sv
// Classifies a word from its error-location vector and syndrome flag.
// Popcount saturates at 2 and is built as an OR/AND reduction tree.
module edc_lq_classify #(
  parameter int DATA_W = edc_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] lq,
  input  logic              syn_nz,
  output edc_pkg::cls_t     cls
);
  import edc_pkg::*;

  localparam int LVLS = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int N    = 1 << LVLS;

  // Pairwise tree: each node carries "any bit set" and "two or more set".
  // Results overwrite low indices in place; index j is written only after
  // its children 2j and 2j+1 have been read.
  function automatic logic [1:0] sat_pop(input logic [N-1:0] v);
    logic [N-1:0] a;
    logic [N-1:0] m;
    a = v;
    m = '0;
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (N >> (l + 1)); j++) begin
        m[j] = m[2*j] | m[2*j+1] | (a[2*j] & a[2*j+1]);
        a[j] = a[2*j] | a[2*j+1];
      end
    end
    return {m[0], a[0]};
  endfunction

  logic [N-1:0] lq_pad;
  logic [1:0]   pop;
  logic         any_set;
  logic         multi_set;

  always_comb begin
    lq_pad = '0;
    lq_pad[DATA_W-1:0] = lq;
  end

  assign pop       = sat_pop(lq_pad);
  assign any_set   = pop[0];
  assign multi_set = pop[1];

  always_comb begin
    cls.flg     = FLG_UNCORR;
    cls.flip_en = 1'b0;
    if (!syn_nz && !any_set) begin
      cls.flg = FLG_CLEAN;
    end else if (syn_nz && any_set && !multi_set) begin
      cls.flg     = FLG_CORR;
      cls.flip_en = 1'b1;
    end
  end

endmodule

// File: rtl/edc_correct_pipe.sv
// Two-stage valid/ready correction pipeline: stage 1 captures the word and
// location vector, stage 2 holds the corrected word and status flags.
module edc_correct_pipe #(
  parameter int DATA_W = edc_pkg::DATA_W,
  parameter int CNT_W  = edc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] cnc,
  input  logic [DATA_W-1:0] lq,
  input  logic              syn_nz,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] cec,
  output edc_pkg::flg_t     flg,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);
  import edc_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              s1_vld;
  logic              s2_vld;
  logic              s1_adv;
  logic              s1_load;
  logic              s2_load;
  logic [DATA_W-1:0] s1_cnc;
  logic [DATA_W-1:0] s1_lq;
  logic              s1_syn;
  cls_t              s1_cls;

  // Ready depends only on downstream state and out_rdy, never on in_vld.
  assign s1_adv  = ~s2_vld | out_rdy;
  assign in_rdy  = ~s1_vld | s1_adv;
  assign s1_load = in_vld & in_rdy;
  assign s2_load = s1_vld & s1_adv;
  assign out_vld = s2_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_cnc <= '0;
      s1_lq  <= '0;
      s1_syn <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_vld <= 1'b1;
        s1_cnc <= cnc;
        s1_lq  <= lq;
        s1_syn <= syn_nz;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
    end
  end

  edc_lq_classify #(
    .DATA_W (DATA_W)
  ) u_classify (
    .lq     (s1_lq),
    .syn_nz (s1_syn),
    .cls    (s1_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      cec    <= '0;
      flg    <= '0;
    end else begin
      if (s1_adv) begin
        s2_vld <= s1_vld;
      end
      if (s2_load) begin
        cec <= s1_cls.flip_en ? (s1_cnc ^ s1_lq) : s1_cnc;
        flg <= s1_cls.flg;
      end
    end
  end

  // Events are counted when a word lands in stage 2; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (s2_load) begin
      if (s1_cls.flg == FLG_CORR && corr_cnt != CNT_MAX) begin
        corr_cnt <= corr_cnt + 1'b1;
      end
      if (s1_cls.flg == FLG_UNCORR && uncorr_cnt != CNT_MAX) begin
        uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edc_correct_pipe.sv
// Directed bench for edc_correct_pipe with a scoreboard of expected words
// and a small reference model of the classification and counters.
module tb_edc_correct_pipe;

  localparam int DW    = 128;
  localparam int CW    = 4;
  localparam int CNT_M = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] cec;
    logic [2:0]    flg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] cnc;
  logic [DW-1:0] lq;
  logic          syn_nz;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] cec;
  logic [2:0]    flg;
  logic          clr_cnt;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  logic          held = 1'b0;
  logic [DW-1:0] held_cec;
  logic [2:0]    held_flg;

  always #5 clk = ~clk;

  edc_correct_pipe #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .cnc        (cnc),
    .lq         (lq),
    .syn_nz     (syn_nz),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .cec        (cec),
    .flg        (flg),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] c, input logic [DW-1:0] l, input logic s);
    exp_t e;
    int   pc;
    pc = $countones(l);
    if (!s && pc == 0) begin
      e.cec = c;
      e.flg = 3'b001;
    end else if (s && pc == 1) begin
      e.cec = c ^ l;
      e.flg = 3'b010;
    end else begin
      e.cec = c;
      e.flg = 3'b100;
    end
    return e;
  endfunction

  // Leaves in_vld high so consecutive calls stream one word per cycle.
  task automatic send(input logic [DW-1:0] c, input logic [DW-1:0] l, input logic s);
    logic ok;
    exp_t e;
    ok = 1'b0;
    cnc = c;
    lq = l;
    syn_nz = s;
    in_vld = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_rdy) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("send_accept", DW'(ok), 1);
    if (ok) begin
      e = model(c, l, s);
      sb.push_back(e);
      n_in++;
      if (e.flg == 3'b010 && exp_corr < CNT_M) exp_corr++;
      if (e.flg == 3'b100 && exp_uncorr < CNT_M) exp_uncorr++;
    end
  endtask

  task automatic send_lat(input string tag, input logic [DW-1:0] c, input logic [DW-1:0] l, input logic s);
    exp_t e;
    e = model(c, l, s);
    send(c, l, s);
    in_vld = 1'b0;
    @(negedge clk);
    check({tag, "_vld_early"}, DW'(out_vld), 0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, DW'(out_vld), 1);
    check({tag, "_cec"}, cec, e.cec);
    check({tag, "_flg"}, DW'(flg), DW'(e.flg));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check({tag, "_drain"}, DW'(sb.size()), 0);
    check({tag, "_words"}, DW'(n_out), DW'(n_in));
    check({tag, "_corr"}, DW'(corr_cnt), DW'(exp_corr));
    check({tag, "_uncorr"}, DW'(uncorr_cnt), DW'(exp_uncorr));
  endtask

  function automatic logic [DW-1:0] onehot(input int idx);
    logic [DW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output monitor: stability while stalled, then scoreboard compare on accept.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_vld", DW'(out_vld), 1);
        check("stall_cec", cec, held_cec);
        check("stall_flg", DW'(flg), DW'(held_flg));
      end
      held = out_vld && !out_rdy;
      held_cec = cec;
      held_flg = flg;
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", DW'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("out_cec", cec, e.cec);
          check("out_flg", DW'(flg), DW'(e.flg));
        end
        n_out++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] l;
    int            kind;

    // 1: reset with in_vld asserted
    rst_n = 1'b0;
    in_vld = 1'b1;
    cnc = rnd_word();
    lq = '0;
    syn_nz = 1'b0;
    out_rdy = 1'b1;
    clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", DW'(out_vld), 0);
    check("rst_cec", cec, 0);
    check("rst_flg", DW'(flg), 0);
    check("rst_corr", DW'(corr_cnt), 0);
    check("rst_uncorr", DW'(uncorr_cnt), 0);
    check("rst_in_rdy", DW'(in_rdy), 1);
    in_vld = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2-4: directed classification with latency check
    send_lat("clean", 128'h0F, 128'h0, 1'b0);
    drain("t2");
    send_lat("corr", 128'h0F, 128'h04, 1'b1);
    check("corr_value", cec, 128'h0B);
    drain("t3");
    send_lat("double", 128'h0F, 128'h06, 1'b1);
    drain("t4a");
    send_lat("spurious", 128'h0F, 128'h01, 1'b0);
    drain("t4b");
    send_lat("syn_nolq", 128'hA5, 128'h0, 1'b1);
    send_lat("corr_msb", 128'h0, onehot(DW - 1), 1'b1);
    check("corr_msb_value", cec, onehot(DW - 1));
    drain("t4c");

    // 5: stream of 8 words with a downstream stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(128'h100 + 128'(i), (i % 2 == 1) ? onehot(i) : 128'h0, i % 2 == 1);
        in_vld = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("full_in_rdy", DW'(in_rdy), 0);
        repeat (2) @(posedge clk);
        #1;
        out_rdy = 1'b1;
        #1;
        check("release_in_rdy", DW'(in_rdy), 1);
      end
    join
    drain("t5");

    // Asynchronous reset with words in flight
    send(128'h11, 128'h0, 1'b0);
    send(128'h22, 128'h0, 1'b0);
    in_vld = 1'b0;
    #2;
    check("pre_rst_vld", DW'(out_vld), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", DW'(out_vld), 0);
    sb.delete();
    n_in = n_out;
    exp_corr = 0;
    exp_uncorr = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    drain("t_rst");

    // Random mix with random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          kind = $urandom_range(0, 4);
          w = rnd_word();
          case (kind)
            0: send(w, 128'h0, 1'b0);
            1: send(w, onehot($urandom_range(0, DW - 1)), 1'b1);
            2: begin
              l = onehot($urandom_range(0, DW / 2 - 1)) | onehot($urandom_range(DW / 2, DW - 1));
              send(w, l, 1'b1);
            end
            3: send(w, onehot($urandom_range(0, DW - 1)), 1'b0);
            default: send(w, 128'h0, 1'b1);
          endcase
        end
        in_vld = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          out_rdy = 1'($urandom_range(0, 1));
        end
        out_rdy = 1'b1;
      end
    join
    out_rdy = 1'b1;
    drain("t_rand");

    // Clear with no event pending
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    check("clr_corr", DW'(corr_cnt), 0);
    check("clr_uncorr", DW'(uncorr_cnt), 0);

    // 6: saturation, then clear racing an increment
    for (int i = 0; i < CNT_M + 2; i++) send(rnd_word(), onehot($urandom_range(0, DW - 1)), 1'b1);
    in_vld = 1'b0;
    drain("t_sat");
    check("sat_value", DW'(corr_cnt), DW'(CNT_M));
    send(rnd_word(), onehot(3), 1'b1);
    in_vld = 1'b0;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    check("clr_wins_corr", DW'(corr_cnt), 0);
    drain("t_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
